// File: rtl/gamma_spike_sched_pkg.sv
// Shared definitions for the gamma-cycle spike scheduler.
//   - default gamma-cycle length and requester count
//   - grant FSM state encoding
package gamma_spike_sched_pkg;

  localparam int unsigned DefGammaCycleWidth = 16;
  localparam int unsigned DefNumReq          = 4;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StOffer = 1'b1
  } sched_state_e;

endpackage

// File: rtl/gamma_spike_sched_rr_pick.sv
// Round-robin picker: returns the first set bit of pending_i at or after ptr_i,
// wrapping modulo NumReq. Purely combinational.
//   pending_i  request vector
//   ptr_i      search start index
//   idx_o      selected index (0 when any_o is low)
//   any_o      at least one request is set
module gamma_spike_sched_rr_pick #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdWidth = 2
) (
  input  logic [NumReq-1:0]  pending_i,
  input  logic [IdWidth-1:0] ptr_i,
  output logic [IdWidth-1:0] idx_o,
  output logic               any_o
);

  logic [IdWidth-1:0] cand;

  always_comb begin
    idx_o = '0;
    cand  = '0;
    any_o = |pending_i;
    // Walk from the farthest offset down so the nearest one to ptr_i wins.
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      cand = IdWidth'((int'(ptr_i) + k) % int'(NumReq));
      if (pending_i[cand]) begin
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/gamma_spike_sched.sv
// Gamma-cycle spike scheduler. A free-running gamma counter time-stamps the first
// spike of each requester per gamma cycle; stamps are offered one at a time, in
// round-robin order, to a shared consumer over a valid/ready handshake.
//   aclk, grst   clock, synchronous active-high reset
//   enable       run gamma cycles (low: counter held at 0, unsent stamps flushed)
//   spike        level-sampled temporal inputs, one per requester
//   out_ready    consumer ready
//   out_valid    stamp offered; out_id / out_time held until accepted, 0 otherwise
//   cycle_start  counter is 0 while enabled
//   overrun      one-cycle pulse after a guard edge that discarded unsent stamps
module gamma_spike_sched
  import gamma_spike_sched_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = DefGammaCycleWidth,
  parameter int unsigned NUM_REQ           = DefNumReq,
  parameter int unsigned TIME_WIDTH        = $clog2(GAMMA_CYCLE_WIDTH),
  parameter int unsigned ID_WIDTH          = $clog2(NUM_REQ)
) (
  input  logic                  aclk,
  input  logic                  grst,
  input  logic                  enable,
  input  logic [NUM_REQ-1:0]    spike,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [TIME_WIDTH-1:0] out_time,
  output logic                  cycle_start,
  output logic                  overrun
);

  localparam logic [TIME_WIDTH-1:0] LastSlot = TIME_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [ID_WIDTH-1:0]   LastId   = ID_WIDTH'(NUM_REQ - 1);

  logic [TIME_WIDTH-1:0] counter_q, counter_d;
  logic [NUM_REQ-1:0]    captured_q, captured_d;
  logic [NUM_REQ-1:0]    pending_q, pending_d;
  logic [TIME_WIDTH-1:0] stamp_q [NUM_REQ];
  logic [TIME_WIDTH-1:0] stamp_d [NUM_REQ];
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [TIME_WIDTH-1:0] time_q, time_d;
  sched_state_e          state_q, state_d;
  logic                  overrun_q, overrun_d;

  logic                  guard, flush, handshake;
  logic [NUM_REQ-1:0]    cap_mask, offered_mask, hs_mask, keep_mask;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_any;

  // Capture, flush and overrun bookkeeping.
  always_comb begin
    guard        = enable && (counter_q == LastSlot);
    flush        = !enable || guard;
    counter_d    = flush ? '0 : counter_q + TIME_WIDTH'(1);
    handshake    = (state_q == StOffer) && out_ready;
    offered_mask = (state_q == StOffer) ? (NUM_REQ'(1) << id_q) : '0;
    hs_mask      = handshake ? offered_mask : '0;
    // The offered entry survives a flush unless it is accepted on that same edge.
    keep_mask    = offered_mask & ~hs_mask;
    cap_mask     = (enable && (counter_q != LastSlot)) ? (spike & ~captured_q) : '0;

    if (flush) begin
      captured_d = captured_q & keep_mask;
      pending_d  = pending_q & keep_mask;
    end else begin
      captured_d = captured_q | cap_mask;
      pending_d  = (pending_q & ~hs_mask) | cap_mask;
    end

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      stamp_d[i] = cap_mask[i] ? counter_q : stamp_q[i];
    end

    // A disable flush is silent; only the guard edge reports lost stamps.
    overrun_d = guard && |(pending_q & ~offered_mask);
  end

  // Picking from the next-state vector lets a capture reach out_valid one edge later.
  gamma_spike_sched_rr_pick #(
    .NumReq  (NUM_REQ),
    .IdWidth (ID_WIDTH)
  ) u_rr_pick (
    .pending_i (pending_d),
    .ptr_i     (rr_ptr_q),
    .idx_o     (pick_idx),
    .any_o     (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    time_d   = time_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StOffer;
          id_d    = pick_idx;
          time_d  = stamp_d[pick_idx];
        end
      end
      StOffer: begin
        if (handshake) begin
          state_d  = StIdle;
          id_d     = '0;
          time_d   = '0;
          rr_ptr_d = (id_q == LastId) ? '0 : id_q + ID_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      counter_q  <= '0;
      captured_q <= '0;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      time_q     <= '0;
      state_q    <= StIdle;
      overrun_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        stamp_q[i] <= '0;
      end
    end else begin
      counter_q  <= counter_d;
      captured_q <= captured_d;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      time_q     <= time_d;
      state_q    <= state_d;
      overrun_q  <= overrun_d;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        stamp_q[i] <= stamp_d[i];
      end
    end
  end

  assign out_valid   = (state_q == StOffer);
  assign out_id      = id_q;
  assign out_time    = time_q;
  assign cycle_start = enable && (counter_q == '0);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_gamma_spike_sched.sv
// Self-checking bench for gamma_spike_sched (16-slot gamma cycle, 4 requesters).
// Tests push expected grants into a scoreboard queue as spikes are driven; a
// negedge monitor pops and compares on every accepted handshake.
module tb_gamma_spike_sched;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] t;
  } exp_t;

  logic       aclk;
  logic       grst;
  logic       enable;
  logic [3:0] spike;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_id;
  logic [3:0] out_time;
  logic       cycle_start;
  logic       overrun;

  int          n_tests;
  int          n_fail;
  int unsigned gc;  // bench model of the gamma counter
  exp_t        sb_q[$];
  exp_t        sb_exp;

  gamma_spike_sched #(
    .GAMMA_CYCLE_WIDTH (16),
    .NUM_REQ           (4)
  ) dut (
    .aclk        (aclk),
    .grst        (grst),
    .enable      (enable),
    .spike       (spike),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_id      (out_id),
    .out_time    (out_time),
    .cycle_start (cycle_start),
    .overrun     (overrun)
  );

  always #5 aclk = ~aclk;

  // Scoreboard monitor: handshakes pop expectations; idle cycles must show zeros.
  always @(negedge aclk) begin
    if (!grst) begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got id=%0d time=%0d, required no grant", out_id, out_time);
        end else begin
          sb_exp = sb_q.pop_front();
          if ({out_id, out_time} !== {sb_exp.id, sb_exp.t}) begin
            n_fail++;
            $display("FAIL sb_grant: got id=%0d time=%0d, required id=%0d time=%0d",
                     out_id, out_time, sb_exp.id, sb_exp.t);
          end
        end
      end else if (!out_valid) begin
        n_tests++;
        if ({out_id, out_time} !== 6'd0) begin
          n_fail++;
          $display("FAIL idle_zero: got id=%0d time=%0d, required 0 0", out_id, out_time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step();
    int unsigned nxt;
    if (grst || !enable || gc == 15) nxt = 0;
    else nxt = gc + 1;
    @(posedge aclk);
    #1;
    gc = nxt;
  endtask

  task automatic run_to(input int unsigned target);
    for (int n = 0; n < 40 && gc != target; n++) step();
    n_tests++;
    if (gc != target) begin
      n_fail++;
      $display("FAIL run_to: got gc=%0d, required %0d", gc, target);
    end
  endtask

  task automatic do_reset();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d undelivered grants, required 0", sb_q.size());
    end
    sb_q.delete();
    spike  = '0;
    enable = 1'b1;
    grst   = 1'b1;
    step();
    grst   = 1'b0;
  endtask

  task automatic test_reset();
    grst = 1'b1; enable = 1'b0; spike = 4'hF; out_ready = 1'b1;
    step(); step();
    n_tests++;
    if ({out_valid, out_id, out_time, overrun, cycle_start} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 0",
               {out_valid, out_id, out_time, overrun, cycle_start});
    end
    spike = '0; grst = 1'b0; enable = 1'b1; #1;
    n_tests++;
    if (cycle_start !== 1'b1) begin
      n_fail++; $display("FAIL cycle_start_on: got %b, required 1", cycle_start);
    end
    step();
    n_tests++;
    if (cycle_start !== 1'b0) begin
      n_fail++; $display("FAIL cycle_start_mid: got %b, required 0", cycle_start);
    end
    run_to(0);
    n_tests++;
    if (cycle_start !== 1'b1) begin
      n_fail++; $display("FAIL cycle_start_wrap: got %b, required 1", cycle_start);
    end
  endtask

  task automatic test_single();
    do_reset(); out_ready = 1'b1;
    run_to(5);
    spike = 4'b0100; sb_q.push_back('{id: 2'd2, t: 4'd5});
    step(); spike = '0;
    n_tests++;
    if ({out_valid, out_id, out_time} !== {1'b1, 2'd2, 4'd5}) begin
      n_fail++;
      $display("FAIL single_offer: got v=%b id=%0d t=%0d, required v=1 id=2 t=5",
               out_valid, out_id, out_time);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_accept: got v=%b, required 0", out_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp_v;
    exp_v = 6'b010101;  // bit k is out_valid at gc 4+k
    do_reset(); out_ready = 1'b1;
    run_to(3);
    spike = 4'b1011;
    sb_q.push_back('{id: 2'd0, t: 4'd3});
    sb_q.push_back('{id: 2'd1, t: 4'd3});
    sb_q.push_back('{id: 2'd3, t: 4'd3});
    step(); spike = '0;
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (out_valid !== exp_v[k]) begin
        n_fail++;
        $display("FAIL simult_pattern: gc=%0d got v=%b, required %b", gc, out_valid, exp_v[k]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); out_ready = 1'b1;
    run_to(2);
    spike = 4'b0001; sb_q.push_back('{id: 2'd0, t: 4'd2});
    step();
    // Requester 1 captures on the same edge requester 0 is accepted.
    spike = 4'b0010; sb_q.push_back('{id: 2'd1, t: 4'd3});
    n_tests++;
    if ({out_valid, out_id} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL b2b_first: got v=%b id=%0d, required v=1 id=0", out_valid, out_id);
    end
    step(); spike = '0;
    step();
    n_tests++;
    if ({out_valid, out_id, out_time} !== {1'b1, 2'd1, 4'd3}) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b id=%0d t=%0d, required v=1 id=1 t=3",
               out_valid, out_id, out_time);
    end
    step();
  endtask

  task automatic test_backpressure();
    do_reset(); out_ready = 1'b0;
    run_to(1);
    spike = 4'b0010; sb_q.push_back('{id: 2'd1, t: 4'd1});
    step(); spike = '0;
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if ({out_valid, out_id, out_time} !== {1'b1, 2'd1, 4'd1}) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d got v=%b id=%0d t=%0d, required v=1 id=1 t=1",
                 k, out_valid, out_id, out_time);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got v=%b, required 0", out_valid);
    end
    // Pointer is now 2: requester 3 must beat requester 0.
    run_to(3);
    spike = 4'b1001;
    sb_q.push_back('{id: 2'd3, t: 4'd3});
    sb_q.push_back('{id: 2'd0, t: 4'd3});
    step(); spike = '0;
    n_tests++;
    if ({out_valid, out_id} !== {1'b1, 2'd3}) begin
      n_fail++; $display("FAIL bp_ptr_first: got v=%b id=%0d, required v=1 id=3", out_valid, out_id);
    end
    step(); step();
    n_tests++;
    if ({out_valid, out_id} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL bp_ptr_wrap: got v=%b id=%0d, required v=1 id=0", out_valid, out_id);
    end
    step();
  endtask

  task automatic test_overrun();
    logic [3:0] exp_ov;
    exp_ov = 4'b0100;  // bit k is overrun at gc 14,15,0,1
    do_reset(); out_ready = 1'b0;
    run_to(13);
    spike = 4'hF; sb_q.push_back('{id: 2'd0, t: 4'd13});
    step(); spike = '0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({overrun, out_valid, out_id, out_time} !== {exp_ov[k], 1'b1, 2'd0, 4'd13}) begin
        n_fail++;
        $display("FAIL overrun_seq: gc=%0d got ov=%b v=%b id=%0d t=%0d, required ov=%b v=1 id=0 t=13",
                 gc, overrun, out_valid, out_id, out_time, exp_ov[k]);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({out_valid, overrun} !== 2'b00) begin
        n_fail++;
        $display("FAIL overrun_dropped: got v=%b ov=%b, required 0 0", out_valid, overrun);
      end
      step();
    end
  endtask

  task automatic test_guard_slot();
    int grants;
    do_reset(); out_ready = 1'b1;
    run_to(15);
    spike = 4'b0010;
    step(); spike = '0;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL guard_no_capture: got v=%b, required 0", out_valid);
      end
      step();
    end
    run_to(0);
    spike = 4'b0010; sb_q.push_back('{id: 2'd1, t: 4'd0});
    grants = 0;
    for (int n = 0; n < 20 && gc != 15; n++) begin
      step();
      if (out_valid) grants++;
    end
    spike = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (out_valid) grants++;
    end
    n_tests++;
    if (grants != 1) begin
      n_fail++; $display("FAIL guard_repeat: got %0d grants, required 1", grants);
    end
  endtask

  task automatic test_enable_off();
    do_reset(); out_ready = 1'b0;
    run_to(4);
    spike = 4'b0101; sb_q.push_back('{id: 2'd0, t: 4'd4});
    step(); spike = '0;
    enable = 1'b0;
    step();
    n_tests++;
    if ({out_valid, out_id, out_time, overrun, cycle_start} !== {1'b1, 2'd0, 4'd4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL enable_off_hold: got v=%b id=%0d t=%0d ov=%b cs=%b, required 1 0 4 0 0",
               out_valid, out_id, out_time, overrun, cycle_start);
    end
    step();
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL enable_off_overrun: got %b, required 0", overrun);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++;
      if ({out_valid, overrun} !== 2'b00) begin
        n_fail++;
        $display("FAIL enable_off_flush: got v=%b ov=%b, required 0 0", out_valid, overrun);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_offer();
    do_reset(); out_ready = 1'b0;
    run_to(6);
    spike = 4'b1000;
    step(); spike = '0;
    n_tests++;
    if ({out_valid, out_id, out_time} !== {1'b1, 2'd3, 4'd6}) begin
      n_fail++;
      $display("FAIL rst_offer_pre: got v=%b id=%0d t=%0d, required v=1 id=3 t=6",
               out_valid, out_id, out_time);
    end
    grst = 1'b1;
    step();
    grst = 1'b0;
    n_tests++;
    if ({out_valid, out_id, out_time, overrun, cycle_start} !== {8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_offer_post: got v=%b id=%0d t=%0d ov=%b cs=%b, required 0 0 0 0 1",
               out_valid, out_id, out_time, overrun, cycle_start);
    end
    out_ready = 1'b1;
    step();
    n_tests++;
    if ({out_valid, cycle_start} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_offer_dropped: got v=%b cs=%b, required 0 0", out_valid, cycle_start);
    end
  endtask

  initial begin
    aclk = 1'b0; grst = 1'b0; enable = 1'b0; spike = '0; out_ready = 1'b0;
    gc = 0; n_tests = 0; n_fail = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_backpressure();
    test_overrun();
    test_guard_slot();
    test_enable_off();
    test_reset_mid_offer();
    step(); step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_final: got %0d undelivered grants, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gamma_spike_sched.md
GAMMA_SPIKE_SCHED -- requirements
Module: gamma_spike_sched

Interface
REQ-001 Parameters: GAMMA_CYCLE_WIDTH, default 16, gamma-cycle length in aclk cycles; NUM_REQ, default 4, temporal requesters; TIME_WIDTH, default $clog2(GAMMA_CYCLE_WIDTH), time-stamp width; ID_WIDTH, default $clog2(NUM_REQ).
REQ-002 Ports SHALL be:
- aclk  in  1  sole clock, rising edge.
- grst  in  1  reset, synchronous, active-high.
- enable  in  1  run gamma cycles.
- spike  in  NUM_REQ  temporal inputs, level-sampled.
- out_ready  in  1  consumer (shared binary-temporal lookup) ready.
- out_valid  out  1  time stamp offered.
- out_id  out  ID_WIDTH  requester index.
- out_time  out  TIME_WIDTH  captured gamma time.
- cycle_start  out  1  high while counter==0 and enable.
- overrun  out  1  one-cycle pulse, pending stamps discarded.

Function
REQ-003 Gamma counter SHALL increment by 1 per cycle while enable=1, wrapping GAMMA_CYCLE_WIDTH-1 -> 0; enable=0 SHALL load 0 on the next edge.
REQ-004 Requester i SHALL capture the counter into stamp[i] and set captured[i] and pending[i] when spike[i]=1, captured[i]=0, enable=1 and counter<GAMMA_CYCLE_WIDTH-1; later spikes in the same gamma cycle SHALL be ignored.
REQ-005 Slot GAMMA_CYCLE_WIDTH-1 SHALL be a guard slot: no capture occurs in it, and on that edge all captured[] and pending[] SHALL clear, except for the entry currently offered.
REQ-006 overrun SHALL pulse in the cycle after the guard edge if at least one pending entry, other than the offered one, was discarded.
REQ-007 The FSM SHALL have states IDLE and OFFER.
REQ-008 IDLE -> OFFER when any pending[] is set: latch grant id = first pending index at or after rr_ptr, modulo NUM_REQ; latency from capture edge to out_valid = 1 cycle minimum.
REQ-009 In OFFER: out_valid=1; out_id and out_time SHALL be held stable from latched registers until handshake (out_valid & out_ready).
REQ-010 On handshake: clear pending[id], set rr_ptr=(id+1) mod NUM_REQ, return to IDLE; maximum throughput is one grant per 2 cycles.
REQ-011 The offered entry SHALL never be retracted by the guard edge, by enable=0, or by a new capture.
REQ-012 A capture and a handshake on the same edge for different indices SHALL both take effect.
REQ-013 enable=0 SHALL clear captured[] and pending[] (except the offered entry) without asserting overrun.
REQ-014 out_id and out_time SHALL be 0 whenever out_valid=0.

Reset
REQ-015 On grst=1 at a rising aclk edge, the following SHALL clear: counter=0, captured[]=0, pending[]=0, stamps=0, rr_ptr=0, FSM=IDLE, out_valid=0, out_id=0, out_time=0, overrun=0, cycle_start=0.
REQ-016 grst SHALL override everything, including a mid-OFFER entry, which is dropped without handshake.

Structure
REQ-017 A shared package SHALL hold the FSM state enum (IDLE, OFFER) and default GAMMA_CYCLE_WIDTH and NUM_REQ constants.
REQ-018 The round-robin pick SHALL be one sub-module, rr_pick: pending vector plus pointer in, index plus any out, purely combinational.

Verification (GAMMA_CYCLE_WIDTH=16, NUM_REQ=4)
REQ-019 Single spike: spike[2] rises at counter=5, out_ready=1 -> out_valid at counter=6 with out_id=2, out_time=5, accepted in one cycle.
REQ-020 Simultaneous spikes: spike[0,1,3] at counter=3, rr_ptr=0, out_ready=1 -> grants in order id 0, 1, 3, all with time 3, on alternating cycles.
REQ-021 Back-pressure: out_ready=0 for 10 cycles during OFFER -> out_id and out_time constant, out_valid held; pointer advances only after acceptance.
REQ-022 Overrun: spikes on all 4 at counter=13 with out_ready=0 -> at the guard edge (counter 15) 3 entries drop, overrun pulses once, the offered entry persists into the next gamma cycle.
REQ-023 Guard slot and repeat spike: spike[1] high only at counter=15 -> no capture; spike[1] held 0..14 -> exactly one grant, time 0.
REQ-024 Reset mid-OFFER: grst pulsed while out_valid=1 -> all outputs 0 next cycle, counter restarts at 0, cycle_start high.
